// File: rtl/rf_param.sv
// rf_param: parametrised register file with two combinational read ports
// (Rn, Rm), one synchronous write port (Rd), an optional hardwired zero
// register and a post-reset clear sweep that zeroes one register per cycle
// before raising ready.
//
// Optional feature, macro RF_BYPASS_EN: when defined, a write in progress is
// forwarded to a read port addressing the same register in the same cycle.
module rf_param #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Rn,
  input  logic [ADDR_W-1:0] Rm,
  input  logic [ADDR_W-1:0] Rd,
  input  logic              enable_registros,
  input  logic [DATA_W-1:0] dataWrite,
  output logic [DATA_W-1:0] busRN,
  output logic [DATA_W-1:0] busRM,
  output logic              ready,
  output logic              clr_busy
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  // Address constants widened/narrowed once so every compare is width-exact.
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ZERO_IDX   = ADDR_W'(ZERO_REG);
  localparam bit                ZERO_EN    = (ZERO_REG < NUM_REGS);

  state_t            state;
  logic [ADDR_W-1:0] clr_idx;
  logic [DATA_W-1:0] regs [NUM_REGS];

  // An address names a real, writable register: in range and not the zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NUM_REGS_W) && !(ZERO_EN && (a == ZERO_IDX));
  endfunction

  logic wr_hit;
  assign wr_hit = enable_registros && addr_ok(Rd);

  // Sweep controller: restart on reset, walk clr_idx to the last register, then go READY.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == LAST_IDX) begin
        state <= READY;
        ready <= 1'b1;
      end
    end
  end

  assign clr_busy = ~ready;

  // Storage: zeroed by the sweep in CLEAR, written through Rd in READY, untouched on reset edges.
  // NOTE: the array has no reset term; the sweep clears it, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        regs[clr_idx] <= '0;
      end else if (wr_hit) begin
        regs[Rd] <= dataWrite;
      end
    end
  end

  // Read port N: zero outside READY or for zero/out-of-range addresses.
  // NOTE: the default assignment first guarantees no latch is inferred.
  always_comb begin
    busRN = '0;
    if (state == READY && addr_ok(Rn)) begin
`ifdef RF_BYPASS_EN
      if (wr_hit && (Rd == Rn)) busRN = dataWrite;
      else                      busRN = regs[Rn];
`else
      busRN = regs[Rn];
`endif
    end
  end

  // Read port M: same rule applied to Rm.
  always_comb begin
    busRM = '0;
    if (state == READY && addr_ok(Rm)) begin
`ifdef RF_BYPASS_EN
      if (wr_hit && (Rd == Rm)) busRM = dataWrite;
      else                      busRM = regs[Rm];
`else
      busRM = regs[Rm];
`endif
    end
  end

endmodule
